// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register ahead of the ALU: valid/ready handshake, MEM/WB operand
// forwarding, and a refresh of the held operands while stalled.
module ex_operand_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] in_rs1_addr,
    input  logic [RA_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [2:0]      in_alu_op,
    input  logic [RA_W-1:0] in_rd_addr,
    input  logic            in_rd_we,
    input  logic            flush,

    input  logic            fwd_mem_we,
    input  logic [RA_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_we,
    input  logic [RA_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [RA_W-1:0] out_rd_addr,
    output logic            out_rd_we
);

    logic            r_valid;
    logic [RA_W-1:0] r_rs1_addr;
    logic [RA_W-1:0] r_rs2_addr;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic            r_use_imm;
    logic [2:0]      r_alu_op;
    logic [RA_W-1:0] r_rd_addr;
    logic            r_rd_we;

    logic            w_accept;
    logic            w_stall;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;

    // x0 is hardwired zero; MEM is younger than WB, so it wins on a double match.
    function automatic logic [XLEN-1:0] f_fwd(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] held,
        input logic            mem_we,
        input logic [RA_W-1:0] mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_we,
        input logic [RA_W-1:0] wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        if (addr == '0) begin
            return '0;
        end else if (mem_we && (mem_rd == addr)) begin
            return mem_data;
        end else if (wb_we && (wb_rd == addr)) begin
            return wb_data;
        end
        return held;
    endfunction

    always_comb begin
        w_fwd_rs1 = f_fwd(r_rs1_addr, r_rs1_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_we, fwd_wb_rd, fwd_wb_data);
        w_fwd_rs2 = f_fwd(r_rs2_addr, r_rs2_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    end

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_stall  = r_valid && !out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (in_ready) begin
            r_valid <= in_valid;
        end
    end

    // Stall refresh captures a forwarded result before its producer retires past WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_use_imm  <= 1'b0;
            r_alu_op   <= '0;
            r_rd_addr  <= '0;
            r_rd_we    <= 1'b0;
        end else if (w_accept) begin
            r_rs1_addr <= in_rs1_addr;
            r_rs2_addr <= in_rs2_addr;
            r_rs1_data <= in_rs1_data;
            r_rs2_data <= in_rs2_data;
            r_imm      <= in_imm;
            r_use_imm  <= in_use_imm;
            r_alu_op   <= in_alu_op;
            r_rd_addr  <= in_rd_addr;
            r_rd_we    <= in_rd_we;
        end else if (w_stall) begin
            r_rs1_data <= w_fwd_rs1;
            r_rs2_data <= w_fwd_rs2;
        end
    end

    assign out_valid   = r_valid;
    assign alu_a       = w_fwd_rs1;
    assign alu_b       = r_use_imm ? r_imm : w_fwd_rs2;
    assign alu_op      = r_alu_op;
    assign out_rs2_val = w_fwd_rs2;
    assign out_rd_addr = r_rd_addr;
    assign out_rd_we   = r_valid && r_rd_we;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed corner cases, a forwarding vector table, and a
// randomized run against a transaction-level model of the stage.
module tb_ex_operand_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RA_W = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid, in_ready;
    logic [RA_W-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic            in_use_imm, in_rd_we, flush;
    logic [2:0]      in_alu_op;
    logic            fwd_mem_we, fwd_wb_we;
    logic [RA_W-1:0] fwd_mem_rd, fwd_wb_rd;
    logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] alu_a, alu_b, out_rs2_val;
    logic [2:0]      alu_op;
    logic [RA_W-1:0] out_rd_addr;
    logic            out_rd_we;

    int n_vec = 0;
    int n_err = 0;

    ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .flush(flush),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_rs2_val(out_rs2_val),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        mem_we;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] exp;
    } fwd_vec_t;

    // A decoded instruction as the model sees it.
    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        use_imm, we;
        logic [2:0]  op;
    } inst_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; out_ready = 1;
        in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_use_imm = 0; in_rd_we = 0; in_alu_op = 0;
        fwd_mem_we = 0; fwd_mem_rd = 0; fwd_mem_data = 0;
        fwd_wb_we = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input inst_t i);
        in_valid = 1; out_ready = 1;
        in_rs1_addr = i.rs1; in_rs2_addr = i.rs2; in_rd_addr = i.rd;
        in_rs1_data = i.d1; in_rs2_data = i.d2; in_imm = i.imm;
        in_use_imm = i.use_imm; in_rd_we = i.we; in_alu_op = i.op;
        step();
        in_valid = 0;
    endtask

    function automatic inst_t mk(input logic [4:0] rs1, input logic [31:0] d1,
                                 input logic [4:0] rs2, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic use_imm,
                                 input logic [2:0] op, input logic [4:0] rd, input logic we);
        inst_t i;
        i.rs1 = rs1; i.d1 = d1; i.rs2 = rs2; i.d2 = d2; i.imm = imm;
        i.use_imm = use_imm; i.op = op; i.rd = rd; i.we = we;
        return i;
    endfunction

    // Reference forwarding from the current bypass inputs.
    function automatic logic [31:0] m_fwd(input logic [4:0] a, input logic [31:0] held);
        if (a == 0) return 32'h0;
        if (fwd_mem_we && fwd_mem_rd == a) return fwd_mem_data;
        if (fwd_wb_we && fwd_wb_rd == a) return fwd_wb_data;
        return held;
    endfunction

    fwd_vec_t vecs[8];
    inst_t    m_inst, nin;
    logic     m_valid;
    logic [31:0] e_rs2;

    initial begin
        idle();
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 0);
        check("reset_in_ready", {31'b0, in_ready}, 1);
        check("reset_alu_a", alu_a, 0);
        check("reset_rd_we", {31'b0, out_rd_we}, 0);
        step(); step();
        rst = 0;

        // Plain issue with no forwarding.
        issue(mk(3, 32'h10, 4, 32'h20, 32'h0, 0, 3'd0, 5'd9, 1));
        check("plain_valid", {31'b0, out_valid}, 1);
        check("plain_a", alu_a, 32'h10);
        check("plain_b", alu_b, 32'h20);
        check("plain_op", {29'b0, alu_op}, 0);
        check("plain_rd", {27'b0, out_rd_addr}, 9);
        check("plain_rd_we", {31'b0, out_rd_we}, 1);

        // Asynchronous reset while holding a valid instruction.
        out_ready = 0;
        #2 rst = 1;
        #1;
        check("rst_mid_valid", {31'b0, out_valid}, 0);
        check("rst_mid_a", alu_a, 0);
        check("rst_mid_b", alu_b, 0);
        check("rst_mid_in_ready", {31'b0, in_ready}, 1);
        step();
        rst = 0;
        idle();

        vecs[0] = '{5, 32'h1234, 1, 5, 32'hAAAA, 1, 5, 32'hBBBB, 32'hAAAA};
        vecs[1] = '{5, 32'h1234, 0, 5, 32'hAAAA, 1, 5, 32'hBBBB, 32'hBBBB};
        vecs[2] = '{0, 32'h1234, 1, 0, 32'hAAAA, 1, 0, 32'hBBBB, 32'h0};
        vecs[3] = '{5, 32'h1234, 1, 6, 32'hAAAA, 1, 5, 32'hBBBB, 32'hBBBB};
        vecs[4] = '{5, 32'h1234, 0, 5, 32'hAAAA, 0, 5, 32'hBBBB, 32'h1234};
        vecs[5] = '{31, 32'hDEAD, 1, 31, 32'hCAFE, 0, 31, 32'hBBBB, 32'hCAFE};
        vecs[6] = '{7, 32'h1, 1, 15, 32'h9, 1, 23, 32'h8, 32'h1};
        vecs[7] = '{16, 32'h2, 0, 16, 32'h9, 1, 0, 32'h8, 32'h2};
        for (int k = 0; k < 8; k++) begin
            issue(mk(vecs[k].addr, vecs[k].data, vecs[k].addr, vecs[k].data,
                     32'h0, 0, 3'd2, 5'd1, 1));
            out_ready = 0;
            fwd_mem_we = vecs[k].mem_we; fwd_mem_rd = vecs[k].mem_rd;
            fwd_mem_data = vecs[k].mem_data;
            fwd_wb_we = vecs[k].wb_we; fwd_wb_rd = vecs[k].wb_rd;
            fwd_wb_data = vecs[k].wb_data;
            #1;
            check($sformatf("fwd_a[%0d]", k), alu_a, vecs[k].exp);
            check($sformatf("fwd_rs2[%0d]", k), out_rs2_val, vecs[k].exp);
            flush = 1;
            step();
            idle();
        end

        // Immediate replaces b, store data still forwarded.
        issue(mk(1, 32'h3, 6, 32'h1, 32'hFFFFFFFC, 1, 3'd0, 5'd2, 1));
        fwd_mem_we = 1; fwd_mem_rd = 6; fwd_mem_data = 32'h7;
        #1;
        check("imm_b", alu_b, 32'hFFFFFFFC);
        check("imm_rs2", out_rs2_val, 32'h7);
        step();
        idle();

        // Stall refresh: WB producer visible for one cycle only.
        issue(mk(3, 32'h11, 4, 32'h22, 32'h0, 0, 3'd1, 5'd8, 1));
        out_ready = 0;
        fwd_wb_we = 1; fwd_wb_rd = 3; fwd_wb_data = 32'h55;
        #1;
        check("stall_a0", alu_a, 32'h55);
        check("stall_in_ready", {31'b0, in_ready}, 0);
        step();
        fwd_wb_we = 0;
        #1;
        check("stall_a1", alu_a, 32'h55);
        step(); step();
        out_ready = 1;
        #1;
        check("stall_a_release", alu_a, 32'h55);
        check("stall_valid", {31'b0, out_valid}, 1);
        check("stall_op", {29'b0, alu_op}, 1);
        step();
        idle();

        // Flush beats a same-cycle accept.
        issue(mk(1, 32'h1, 2, 32'h2, 32'h0, 0, 3'd3, 5'd4, 1));
        check("flush_pre_valid", {31'b0, out_valid}, 1);
        in_valid = 1; in_rs1_addr = 9; in_rs1_data = 32'h99; in_alu_op = 3'd7;
        in_rd_addr = 5'd17; flush = 1;
        step();
        idle();
        check("flush_valid", {31'b0, out_valid}, 0);
        check("flush_rd_we", {31'b0, out_rd_we}, 0);
        step();
        check("flush_never_valid", {31'b0, out_valid}, 0);
        check("flush_op_kept", {29'b0, alu_op}, 3);

        // Randomized run against a transaction-level model.
        rst = 1;
        step();
        rst = 0;
        m_valid = 0;
        m_inst = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            nin = mk($urandom_range(0, 3), $urandom, $urandom_range(0, 3), $urandom,
                     $urandom, $urandom_range(0, 1), $urandom_range(0, 7),
                     $urandom_range(0, 31), $urandom_range(0, 1));
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 9) == 0);
            in_rs1_addr = nin.rs1; in_rs2_addr = nin.rs2; in_rd_addr = nin.rd;
            in_rs1_data = nin.d1; in_rs2_data = nin.d2; in_imm = nin.imm;
            in_use_imm = nin.use_imm; in_rd_we = nin.we; in_alu_op = nin.op;
            fwd_mem_we = $urandom_range(0, 1); fwd_mem_rd = $urandom_range(0, 3);
            fwd_mem_data = $urandom;
            fwd_wb_we = $urandom_range(0, 1); fwd_wb_rd = $urandom_range(0, 3);
            fwd_wb_data = $urandom;
            @(negedge clk);
            e_rs2 = m_fwd(m_inst.rs2, m_inst.d2);
            check("rnd_valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("rnd_in_ready", {31'b0, in_ready}, {31'b0, !m_valid || out_ready});
            check("rnd_a", alu_a, m_fwd(m_inst.rs1, m_inst.d1));
            check("rnd_b", alu_b, m_inst.use_imm ? m_inst.imm : e_rs2);
            check("rnd_rs2", out_rs2_val, e_rs2);
            check("rnd_op", {29'b0, alu_op}, {29'b0, m_inst.op});
            check("rnd_rd", {27'b0, out_rd_addr}, {27'b0, m_inst.rd});
            check("rnd_rd_we", {31'b0, out_rd_we}, {31'b0, m_valid && m_inst.we});
            // Advance the model with the inputs that the coming edge will see.
            if (flush) begin
                m_valid = 0;
            end else if (in_valid && (!m_valid || out_ready)) begin
                m_valid = 1;
                m_inst = nin;
            end else if (m_valid && !out_ready) begin
                m_inst.d1 = m_fwd(m_inst.rs1, m_inst.d1);
                m_inst.d2 = e_rs2;
            end else begin
                m_valid = 0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the 32-bit ALU (ops 0..7: add, sub, and, or, xor, sll, srl, sra).
- Latches decoded instructions with a valid/ready handshake.
- Resolves operand forwarding from the MEM and WB stages.
- Drives the ALU a/b/op inputs plus the destination info consumed by the EX/MEM register.
- Keeps forwarded values alive across stalls so a retiring producer never loses its result.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register-address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  decode offers an instruction
in_ready  out  1  stage can accept this cycle
in_rs1_addr  in  RA_W  source 1 address
in_rs2_addr  in  RA_W  source 2 address
in_rs1_data  in  XLEN  register-file value of rs1
in_rs2_data  in  XLEN  register-file value of rs2
in_imm  in  XLEN  sign-extended immediate
in_use_imm  in  1  1: ALU b = immediate
in_alu_op  in  3  ALU operation code
in_rd_addr  in  RA_W  destination address
in_rd_we  in  1  destination write enable
flush  in  1  kill held and incoming instruction
fwd_mem_we  in  1  MEM-stage result valid for writeback
fwd_mem_rd  in  RA_W  MEM-stage destination
fwd_mem_data  in  XLEN  MEM-stage result
fwd_wb_we  in  1  WB-stage write enable
fwd_wb_rd  in  RA_W  WB-stage destination
fwd_wb_data  in  XLEN  WB-stage result
out_valid  out  1  ALU inputs valid
out_ready  in  1  EX/MEM can accept
alu_a  out  XLEN  ALU operand a
alu_b  out  XLEN  ALU operand b
alu_op  out  3  ALU op
out_rs2_val  out  XLEN  forwarded rs2 (store data)
out_rd_addr  out  RA_W  held destination
out_rd_we  out  1  held write enable, gated by out_valid

Behaviour:
Reset:
- While rst=1, all state clears asynchronously: out_valid=0, held data/addrs/op/imm=0.
- As a result alu_a=alu_b=out_rs2_val=0, alu_op=0, out_rd_we=0, and in_ready=1.

Handshake:
- in_ready = !out_valid | out_ready (combinational).
- Accept when in_valid & in_ready & !flush. The instruction appears on the outputs the next cycle (latency 1).
- Throughput is one instruction per cycle.
- Outputs are held stable while out_valid & !out_ready.

Flush:
- flush=1 clears out_valid at the next edge.
- Any same-cycle incoming instruction is dropped.
- flush has priority over accept and stall.

Forwarding (combinational on held state, per source s ∈ {rs1, rs2}):
- If s_addr==0: value = 0.
- Else if fwd_mem_we & fwd_mem_rd==s_addr: value = fwd_mem_data.
- Else if fwd_wb_we & fwd_wb_rd==s_addr: value = fwd_wb_data.
- Else: value = held register-file data.
- MEM beats WB when both match.

Operand outputs:
- alu_a = fwd(rs1).
- alu_b = held_use_imm ? held_imm : fwd(rs2).
- out_rs2_val = fwd(rs2) always.
- alu_op = held op.

Stall refresh:
- Each cycle out_valid & !out_ready & !flush, held rs1/rs2 data are overwritten with the current fwd(rs1)/fwd(rs2).
- A producer that retires past WB during the stall stays visible.
- Refresh does not alter addresses, op, imm or rd.

Bubbles:
- When out_valid=0, out_rd_we=0. Operand outputs are don't-care but must stay deterministic (held values).

Widths:
- No arithmetic is done here. All data is passed full XLEN. Address compares are exact RA_W-bit.

Test Plan:
- Reset mid-transfer: assert rst with out_valid=1 -> out_valid=0, alu_a=0, alu_b=0 immediately (async); in_ready=1.
- Plain issue: rs1=3 data 0x10, rs2=4 data 0x20, op=0, no forwarding, out_ready=1 -> next cycle alu_a=0x10, alu_b=0x20, alu_op=0, out_valid=1.
- Forward priority: held rs1=5; fwd_mem (we=1, rd=5, 0xAAAA) and fwd_wb (we=1, rd=5, 0xBBBB) -> alu_a=0xAAAA. Drop fwd_mem_we -> 0xBBBB. With rs1=0 and both matching rd=0 -> 0.
- Immediate: use_imm=1, imm=0xFFFFFFFC, rs2 forwarded 0x7 -> alu_b=0xFFFFFFFC, out_rs2_val=0x7.
- Stall refresh: out_ready=0; WB forwards rd=3=0x55 for one cycle, then fwd_wb_we=0; out_ready=1 two cycles later -> alu_a still 0x55; in_ready=0 during stall.
- Flush vs accept: out_valid=1, in_valid=1, flush=1 same cycle -> next cycle out_valid=0 and the new instruction never appears.
